lpif_rx_x4_asym2_full_slave_align: RTL
======================================

Name: lpif_rx_x4_asym2_full_slave_align

Overview:
- Slave-end receive aligner and unpacker for the x4 asym2 LPIF link.
- The half-rate master ships two 77-bit flits per half-rate word. The full-rate slave receives them one flit per clk_wr cycle on rx_phy0.
- The block waits out the online delay, then locks to the persistent marker that tags the first flit of each pair.
- Once locked, it unpacks each flit into single-flit LPIF upstream fields, with a pair-phase indication for the slave adapter.

Parameters:
- LOCK_CNT, 4: consecutive correctly alternating marker words required to declare lock.
- MISS_MAX, 2: consecutive marker mismatches while locked that force a relock; legal range 1..15.

Ports:
- clk_wr  in  1  single clock; all logic on rising edge.
- rst_wr  in  1  synchronous, active-high reset.
- rx_online  in  1  PHY receive path online.
- m_gen2_mode  in  1  1 = Gen2 (only supported mode).
- delay_x_value  in  16  cycles to wait after rx_online before hunting.
- rx_phy0  in  80  per-cycle PHY word: [3:0] state, [5:4] protid, [69:6] data, [70] dvalid, [74:71] crc, [75] crc_valid, [76] valid, [77] marker, [79:78] reserved (ignored).
- ustrm_state  out  4  unpacked flit state.
- ustrm_protid  out  2  unpacked protocol id.
- ustrm_data  out  64  unpacked data.
- ustrm_dvalid  out  1  data valid.
- ustrm_crc  out  4  crc nibble.
- ustrm_crc_valid  out  1  crc valid.
- ustrm_valid  out  1  flit valid.
- ustrm_phase  out  1  0 = first flit of pair, 1 = second.
- rx_align_done  out  1  lock achieved.
- rx_upstream_debug_status  out  32  [31:29] FSM state, [28] rx_align_done, [27] rx_online, [23:16] pair-error count (feature only, else 0), [15:0] relock count (saturating).

Behaviour:
- Reset: all outputs 0. FSM = IDLE. All counters 0.
- FSM encoding: IDLE=0, DELAY=1, HUNT=2, LOCKED=3.
- IDLE:
  - Go to DELAY when rx_online=1 and m_gen2_mode=1.
  - Delay counter is loaded with 0 on entry.
- DELAY:
  - Counter increments each cycle.
  - When counter == delay_x_value, go to HUNT.
  - delay_x_value=0 gives exactly one cycle in DELAY.
- HUNT, pair detection:
  - Expected phase toggles every cycle.
  - A word with marker=1 restarts the good count at 1 and sets the next expected marker to 0.
  - A good word is any word whose marker equals the expected value; good count increments.
  - Any mismatch clears the good count to 0.
- HUNT, lock:
  - When good count reaches LOCK_CNT, go to LOCKED.
  - On that transition: rx_align_done=1, and the phase register is set so the next word is treated as phase 0 if the last word had marker=0, phase 1 otherwise.
- LOCKED, per word:
  - Marker must equal (phase==0).
  - A mismatch increments the miss count; a match clears it.
  - When miss count == MISS_MAX: go to HUNT, clear rx_align_done, relock count +1 (saturates at 16'hFFFF).
- Exit to IDLE from any non-IDLE state, next cycle, when rx_online=0 or m_gen2_mode=0. This clears rx_align_done, the data outputs and the phase.
- Data path:
  - Latency is 1 cycle: rx_phy0 sampled at edge N appears on ustrm_* after edge N.
  - ustrm_* are driven from rx_phy0 only when the FSM is LOCKED in the sampling cycle; otherwise all are 0.
  - A word that causes a miss is still forwarded.
  - The word that causes the exit to HUNT is forwarded, because it was sampled while the FSM was LOCKED.
- ustrm_phase reflects the phase of the forwarded word. It is 0 whenever outputs are zeroed.
- Reserved bits [79:78] never affect behaviour.
- rst_wr has priority over all events.
- Reset asserted mid-lock: outputs 0 on the next cycle.

Optional Feature:
- Macro: LPIF_RX_ASYM2_PAIR_CHECK_EN.
- Defined:
  - In LOCKED, a phase-1 word with valid=1 whose preceding phase-0 word had valid=0 is a pair error.
  - Each pair error increments an 8-bit saturating counter shown in debug[23:16].
  - The counter clears on reset or on entry to IDLE.
- Undefined: no checker logic; debug[23:16] is tied to 0.

Test Plan:
- Reset, rx_online=1, delay_x_value=5, alternating markers 1,0,1,0… -> 6 cycles in DELAY, then 4 good words, then rx_align_done=1. First forwarded word has ustrm_phase=0.
- Locked, rx_phy0 data field=64'hDEADBEEF_01234567, valid=1 -> same value on ustrm_data the next cycle with ustrm_valid=1. The other fields map bit-exactly.
- Locked, one bad marker then a correct one -> stays locked, relock count 0. Two consecutive bad markers (MISS_MAX=2) -> HUNT, rx_align_done=0, relock count=1, outputs 0 from the following cycle.
- rx_online dropped while locked -> IDLE the next cycle, all ustrm_* 0. Reassert -> full DELAY/HUNT sequence repeats.
- m_gen2_mode=0 with rx_online=1 -> FSM stays IDLE, debug[31:29]=0. rst_wr pulsed mid-lock -> every output 0 one cycle later.
- With LPIF_RX_ASYM2_PAIR_CHECK_EN: phase-0 valid=0 followed by phase-1 valid=1, three times -> debug[23:16]=3. Without the macro -> debug[23:16]=0.

Source files
------------

// File: rtl/lpif_rx_x4_asym2_full_slave_align.sv
// Slave-end receive aligner/unpacker for the x4 asym2 LPIF link: waits out the online delay,
// locks to the pair marker, then forwards one flit per cycle. Optional pair checker: LPIF_RX_ASYM2_PAIR_CHECK_EN.
module lpif_rx_x4_asym2_full_slave_align #(
    parameter int LOCK_CNT = 4,
    parameter int MISS_MAX = 2
) (
    input  logic        clk_wr,
    input  logic        rst_wr,
    input  logic        rx_online,
    input  logic        m_gen2_mode,
    input  logic [15:0] delay_x_value,
    input  logic [79:0] rx_phy0,
    output logic [3:0]  ustrm_state,
    output logic [1:0]  ustrm_protid,
    output logic [63:0] ustrm_data,
    output logic        ustrm_dvalid,
    output logic [3:0]  ustrm_crc,
    output logic        ustrm_crc_valid,
    output logic        ustrm_valid,
    output logic        ustrm_phase,
    output logic        rx_align_done,
    output logic [31:0] rx_upstream_debug_status
);
    localparam int GW = $clog2(LOCK_CNT + 1);
    localparam logic [GW-1:0] LOCK_W = GW'(LOCK_CNT);
    localparam logic [3:0] MISS_W = 4'(MISS_MAX);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_DELAY  = 3'd1,
        ST_HUNT   = 3'd2,
        ST_LOCKED = 3'd3
    } state_t;

    state_t        state_r, state_s;
    logic [15:0]   dly_r, dly_s;
    logic [GW-1:0] good_r, good_s;
    logic          exp_r, exp_s;
    logic          phase_r, phase_s;
    logic          done_r, done_s;
    logic [3:0]    miss_r, miss_s;
    logic [15:0]   relock_r, relock_s;
    logic          online_r;
    logic          link_ok_s, marker_s, fwd_s;
    logic [7:0]    pair_err_s;
    logic          unused_rsvd_s;

    assign link_ok_s     = rx_online & m_gen2_mode;
    assign marker_s      = rx_phy0[77];
    assign fwd_s         = (state_r == ST_LOCKED) & link_ok_s;
    assign unused_rsvd_s = ^rx_phy0[79:78];

    // Next-state and alignment bookkeeping
    always_comb begin
        state_s  = state_r;
        dly_s    = dly_r;
        good_s   = good_r;
        exp_s    = exp_r;
        phase_s  = phase_r;
        done_s   = done_r;
        miss_s   = miss_r;
        relock_s = relock_r;
        if ((state_r != ST_IDLE) && !link_ok_s) begin
            state_s = ST_IDLE;
            done_s  = 1'b0;
            phase_s = 1'b0;
            good_s  = '0;
            miss_s  = 4'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (link_ok_s) begin
                        state_s = ST_DELAY;
                        dly_s   = 16'd0;
                    end else begin
                        state_s = ST_IDLE;
                    end
                end
                ST_DELAY: begin
                    if (dly_r == delay_x_value) begin
                        state_s = ST_HUNT;
                        good_s  = '0;
                        exp_s   = 1'b1;
                    end else begin
                        dly_s = dly_r + 16'd1;
                    end
                end
                ST_HUNT: begin
                    // A stray marker always starts a fresh pair sequence
                    if (marker_s == exp_r) begin
                        good_s = good_r + GW'(1);
                        exp_s  = ~exp_r;
                    end else if (marker_s) begin
                        good_s = GW'(1);
                        exp_s  = 1'b0;
                    end else begin
                        good_s = '0;
                        exp_s  = ~exp_r;
                    end
                    if (good_s == LOCK_W) begin
                        state_s = ST_LOCKED;
                        done_s  = 1'b1;
                        phase_s = marker_s;
                        miss_s  = 4'd0;
                    end else begin
                        state_s = ST_HUNT;
                    end
                end
                ST_LOCKED: begin
                    phase_s = ~phase_r;
                    if (marker_s == ~phase_r) begin
                        miss_s = 4'd0;
                    end else begin
                        miss_s = miss_r + 4'd1;
                    end
                    if (miss_s == MISS_W) begin
                        state_s  = ST_HUNT;
                        done_s   = 1'b0;
                        good_s   = '0;
                        exp_s    = 1'b1;
                        relock_s = (relock_r == 16'hFFFF) ? relock_r : relock_r + 16'd1;
                    end else begin
                        state_s = ST_LOCKED;
                    end
                end
                default: begin
                    state_s = ST_IDLE;
                end
            endcase
        end
    end

    // State and counter registers
    always_ff @(posedge clk_wr) begin
        if (rst_wr) begin
            state_r  <= ST_IDLE;
            dly_r    <= 16'd0;
            good_r   <= '0;
            exp_r    <= 1'b0;
            phase_r  <= 1'b0;
            done_r   <= 1'b0;
            miss_r   <= 4'd0;
            relock_r <= 16'd0;
            online_r <= 1'b0;
        end else begin
            state_r  <= state_s;
            dly_r    <= dly_s;
            good_r   <= good_s;
            exp_r    <= exp_s;
            phase_r  <= phase_s;
            done_r   <= done_s;
            miss_r   <= miss_s;
            relock_r <= relock_s;
            online_r <= rx_online;
        end
    end

    // Output stage: forward the sampled flit only while locked
    always_ff @(posedge clk_wr) begin
        if (rst_wr) begin
            ustrm_state     <= 4'd0;
            ustrm_protid    <= 2'd0;
            ustrm_data      <= 64'd0;
            ustrm_dvalid    <= 1'b0;
            ustrm_crc       <= 4'd0;
            ustrm_crc_valid <= 1'b0;
            ustrm_valid     <= 1'b0;
            ustrm_phase     <= 1'b0;
        end else if (fwd_s) begin
            ustrm_state     <= rx_phy0[3:0];
            ustrm_protid    <= rx_phy0[5:4];
            ustrm_data      <= rx_phy0[69:6];
            ustrm_dvalid    <= rx_phy0[70];
            ustrm_crc       <= rx_phy0[74:71];
            ustrm_crc_valid <= rx_phy0[75];
            ustrm_valid     <= rx_phy0[76];
            ustrm_phase     <= phase_r;
        end else begin
            ustrm_state     <= 4'd0;
            ustrm_protid    <= 2'd0;
            ustrm_data      <= 64'd0;
            ustrm_dvalid    <= 1'b0;
            ustrm_crc       <= 4'd0;
            ustrm_crc_valid <= 1'b0;
            ustrm_valid     <= 1'b0;
            ustrm_phase     <= 1'b0;
        end
    end

`ifdef LPIF_RX_ASYM2_PAIR_CHECK_EN
    logic       prev0_valid_r;
    logic [7:0] pair_err_r;

    // Pair checker: a valid phase-1 flit needs a valid phase-0 partner
    always_ff @(posedge clk_wr) begin
        if (rst_wr) begin
            prev0_valid_r <= 1'b0;
            pair_err_r    <= 8'd0;
        end else if (state_s == ST_IDLE) begin
            prev0_valid_r <= 1'b0;
            pair_err_r    <= 8'd0;
        end else if (fwd_s && !phase_r) begin
            prev0_valid_r <= rx_phy0[76];
        end else if (fwd_s && rx_phy0[76] && !prev0_valid_r && (pair_err_r != 8'hFF)) begin
            pair_err_r <= pair_err_r + 8'd1;
        end else begin
            pair_err_r <= pair_err_r;
        end
    end

    assign pair_err_s = pair_err_r;
`else
    assign pair_err_s = 8'd0;
`endif

    assign rx_align_done            = done_r;
    assign rx_upstream_debug_status = {state_r, done_r, online_r, 3'b000, pair_err_s, relock_r};

endmodule
